// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one memory read port between the I-side and D-side page-table walkers.
// Define PTW_ARB_RR_EN for round-robin tie breaking; otherwise the D-side always wins a tie.
module ptw_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_pte,
    output logic              i_pte_valid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_pte,
    output logic              d_pte_valid,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_ok,
    input  logic [DATA_W-1:0] m_data,
    output logic [1:0]        grant
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state;
    logic              owner_d;
    logic              owner_req;
    logic              pick_d;
    logic [ADDR_W-1:0] pick_addr;

    assign owner_req = owner_d ? d_req : i_req;
    assign pick_addr = (pick_d ? d_addr : i_addr) & ~ADDR_W'(7);

`ifdef PTW_ARB_RR_EN
    // rr_ptr names the side favoured on the next tie; it flips away from each winner
    logic rr_ptr;
    assign pick_d = d_req && (!i_req || rr_ptr);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= 1'b1;
        else if (state == IDLE && (i_req || d_req))
            rr_ptr <= !pick_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            m_valid     <= 1'b0;
            m_addr      <= '0;
            i_pte       <= '0;
            d_pte       <= '0;
            i_pte_valid <= 1'b0;
            d_pte_valid <= 1'b0;
            grant       <= 2'b00;
        end else begin
            i_pte_valid <= 1'b0;
            d_pte_valid <= 1'b0;
            case (state)
                IDLE: if (i_req || d_req) begin
                    state   <= BUSY;
                    owner_d <= pick_d;
                    m_valid <= 1'b1;
                    m_addr  <= pick_addr;
                    grant   <= pick_d ? 2'b10 : 2'b01;
                end
                BUSY: if (!owner_req) begin
                    // a flush that coincides with completion just discards the data
                    if (m_ok) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        grant   <= 2'b00;
                    end else begin
                        state <= DRAIN;
                    end
                end else if (m_ok) begin
                    state   <= RESP;
                    m_valid <= 1'b0;
                    grant   <= 2'b00;
                    if (owner_d) begin
                        d_pte       <= m_data;
                        d_pte_valid <= 1'b1;
                    end else begin
                        i_pte       <= m_data;
                        i_pte_valid <= 1'b1;
                    end
                end
                RESP: state <= IDLE;
                DRAIN: if (m_ok) begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    grant   <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: directed scenarios plus randomized walkers against a transaction-level model.
module tb_ptw_mem_arbiter;
    logic        clk, reset;
    logic        i_req, d_req, m_ok;
    logic [63:0] i_addr, d_addr, m_data;
    logic [63:0] i_pte, d_pte, m_addr;
    logic        i_pte_valid, d_pte_valid, m_valid;
    logic [1:0]  grant;

    ptw_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_pte(i_pte), .i_pte_valid(i_pte_valid),
        .d_req(d_req), .d_addr(d_addr), .d_pte(d_pte), .d_pte_valid(d_pte_valid),
        .m_valid(m_valid), .m_addr(m_addr), .m_ok(m_ok), .m_data(m_data), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmps = 0;
    int errs = 0;

    // reference model: who owns the port, and whether a response gap or drain is pending
    int          e_own;
    bit          e_resp, e_drain, pref_d;
    bit          e_mv, e_ipv, e_dpv;
    logic [63:0] e_addr, e_ipte, e_dpte;
    logic [1:0]  e_grant;

    int i_left, d_left, mem_lat, mem_cnt;
    bit auto_mem, rnd;
    int served[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmps++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_own = 0; e_resp = 0; e_drain = 0; pref_d = 1;
        e_mv = 0; e_ipv = 0; e_dpv = 0;
        e_addr = '0; e_ipte = '0; e_dpte = '0; e_grant = 2'b00;
    endtask

    task automatic model_step();
        bit oreq, pd;
        e_ipv = 0;
        e_dpv = 0;
        if (e_resp) begin
            e_resp = 0;
        end else if (e_own == 0) begin
            if (i_req || d_req) begin
                pd = d_req && (!i_req || pref_d);
`ifdef PTW_ARB_RR_EN
                pref_d = !pd;
`endif
                e_own = pd ? 2 : 1;
                e_mv = 1;
                e_grant = pd ? 2'b10 : 2'b01;
                e_addr = (pd ? d_addr : i_addr) & ~64'h7;
            end
        end else begin
            oreq = (e_own == 2) ? d_req : i_req;
            if (e_drain || !oreq) begin
                if (m_ok) begin
                    e_own = 0; e_drain = 0; e_mv = 0; e_grant = 2'b00;
                end else begin
                    e_drain = 1;
                end
            end else if (m_ok) begin
                if (e_own == 2) begin e_dpte = m_data; e_dpv = 1; end
                else begin e_ipte = m_data; e_ipv = 1; end
                e_own = 0; e_resp = 1; e_mv = 0; e_grant = 2'b00;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(e_mv));
        chk({tag, ".m_addr"}, m_addr, e_addr);
        chk({tag, ".grant"}, 64'(grant), 64'(e_grant));
        chk({tag, ".i_pte_valid"}, 64'(i_pte_valid), 64'(e_ipv));
        chk({tag, ".d_pte_valid"}, 64'(d_pte_valid), 64'(e_dpv));
        chk({tag, ".i_pte"}, i_pte, e_ipte);
        chk({tag, ".d_pte"}, d_pte, e_dpte);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // walkers advance on their own pte_valid; memory answers after mem_lat cycles
    task automatic agents();
        if (i_pte_valid) begin
            served.push_back(1);
            i_left--;
            if (i_left <= 0) i_req = 0;
            else i_addr = i_addr + 64'h1000;
        end
        if (d_pte_valid) begin
            served.push_back(2);
            d_left--;
            if (d_left <= 0) d_req = 0;
            else d_addr = d_addr + 64'h1000;
        end
        if (rnd) begin
            if (!i_req && $urandom_range(3) == 0) begin
                i_req = 1; i_addr = {$urandom, $urandom}; i_left = $urandom_range(3, 1);
            end else if (i_req && $urandom_range(15) == 0) i_req = 0;
            if (!d_req && $urandom_range(3) == 0) begin
                d_req = 1; d_addr = {$urandom, $urandom}; d_left = $urandom_range(3, 1);
            end else if (d_req && $urandom_range(15) == 0) d_req = 0;
        end
        if (auto_mem) begin
            m_ok = 0;
            if (m_valid) begin
                if (mem_cnt >= mem_lat) begin
                    m_ok = 1; m_data = {$urandom, $urandom}; mem_cnt = 0;
                    if (rnd) mem_lat = $urandom_range(3, 0);
                end else mem_cnt++;
            end else if (rnd && $urandom_range(7) == 0) begin
                m_ok = 1; m_data = {$urandom, $urandom};
            end
        end
    endtask

    initial begin
        int exp_order[4];
        logic [63:0] reads[$];
        bit prev_mv;
        reset = 0; i_req = 0; d_req = 0; m_ok = 0;
        i_addr = '0; d_addr = '0; m_data = '0;
        auto_mem = 0; rnd = 0; mem_lat = 0; mem_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1;

        // single I-side read with 3-cycle memory latency
        i_req = 1; i_addr = 64'h8000_100C;
        step("t1.grant");
        chk("t1.m_addr_const", m_addr, 64'h8000_1008);
        chk("t1.grant_const", 64'(grant), 64'h1);
        step("t1.wait1");
        step("t1.wait2");
        m_ok = 1; m_data = 64'h2000_0001;
        step("t1.resp");
        chk("t1.ipv_const", 64'(i_pte_valid), 64'h1);
        chk("t1.ipte_const", i_pte, 64'h2000_0001);
        chk("t1.dpv_const", 64'(d_pte_valid), 64'h0);
        i_req = 0; m_ok = 0;
        step("t1.after");
        chk("t1.ipv_clear", 64'(i_pte_valid), 64'h0);

        // simultaneous requests, two reads each, immediate completion
        auto_mem = 1; mem_lat = 0; mem_cnt = 0; served.delete();
        i_req = 1; i_addr = 64'h1000; i_left = 2;
        d_req = 1; d_addr = 64'h9000; d_left = 2;
        for (int k = 0; k < 30; k++) begin
            step("t2");
            agents();
        end
`ifdef PTW_ARB_RR_EN
        exp_order = '{2, 1, 2, 1};
`else
        exp_order = '{2, 2, 1, 1};
`endif
        chk("t2.count", 64'(served.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2.order%0d", k), 64'(k < served.size() ? served[k] : 0), 64'(exp_order[k]));
        auto_mem = 0; m_ok = 0;

        // D flushes right after grant while I waits
        d_req = 1; d_addr = 64'hA000_0010;
        step("t3.grant");
        chk("t3.grant_const", 64'(grant), 64'h2);
        i_req = 1; i_addr = 64'hB000_0023;
        step("t3.busy");
        d_req = 0;
        for (int k = 0; k < 4; k++) begin
            step("t3.drain");
            chk("t3.mv_held", 64'(m_valid), 64'h1);
        end
        m_ok = 1; m_data = 64'hDEAD;
        step("t3.ok");
        chk("t3.no_dpv", 64'(d_pte_valid), 64'h0);
        chk("t3.mv_drop", 64'(m_valid), 64'h0);
        m_ok = 0;
        step("t3.igrant");
        chk("t3.iaddr_const", m_addr, 64'hB000_0020);
        m_ok = 1; m_data = 64'h55;
        step("t3.iresp");
        i_req = 0; m_ok = 0;
        step("t3.idle");

        // three-level I-side walk
        auto_mem = 1; mem_lat = 1; mem_cnt = 0; served.delete();
        i_req = 1; i_addr = 64'h8000_0000; i_left = 3;
        prev_mv = 0;
        for (int k = 0; k < 40; k++) begin
            step("t4");
            if (m_valid && !prev_mv) reads.push_back(m_addr);
            prev_mv = m_valid;
            agents();
        end
        chk("t4.reads", 64'(reads.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t4.addr%0d", k), k < reads.size() ? reads[k] : 64'hX,
                64'h8000_0000 + 64'(k) * 64'h1000);
        auto_mem = 0; m_ok = 0;

        // asynchronous reset mid-BUSY
        i_req = 1; i_addr = 64'h4000;
        step("t5.grant");
        #3 reset = 0;
        model_reset();
        #1;
        chk("t5.mv", 64'(m_valid), 64'h0);
        chk("t5.grant", 64'(grant), 64'h0);
        chk("t5.ipv", 64'(i_pte_valid), 64'h0);
        check_all("t5.rst");
        @(posedge clk);
        #1 reset = 1; i_addr = 64'h5008;
        step("t5.regrant");
        m_ok = 1; m_data = 64'h77;
        step("t5.resp");
        i_req = 0; m_ok = 0;
        step("t5.idle");

        // stray m_ok while idle
        m_ok = 1; m_data = 64'hBAD;
        step("t6.stray");
        m_ok = 0; d_req = 1; d_addr = 64'h6000;
        step("t6.grant");
        chk("t6.mv_const", 64'(m_valid), 64'h1);
        m_ok = 1; m_data = 64'h66;
        step("t6.resp");
        d_req = 0; m_ok = 0;
        step("t6.idle");

        // randomized walkers, flushes and memory latency
        rnd = 1; auto_mem = 1; mem_lat = 2; mem_cnt = 0;
        for (int k = 0; k < 2000; k++) begin
            step("rand");
            agents();
        end
        rnd = 0; i_req = 0; d_req = 0; mem_lat = 0;
        for (int k = 0; k < 10; k++) begin
            step("tail");
            agents();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
